// File: rtl/ram_pkg.sv
// Shared widths, FSM encoding and memory request payload for the RAM write loader
// and the memory model that sits behind it.
package ram_pkg;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WRITE      = 3'd1,
        VERIFY_RD  = 3'd2,
        VERIFY_CMP = 3'd3,
        DONE       = 3'd4
    } state_t;

    typedef struct packed {
        logic              en;
        logic              r_w;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
    } mem_req_t;

    // Bursts longer than the memory are limited to one full pass.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] cnt);
        return (cnt > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : cnt;
    endfunction
endpackage

// File: rtl/ram_write_loader.sv
// Streams a burst of words into a single-port RAM, optionally reading the burst
// back and comparing it against an internal shadow copy.
module ram_write_loader
    import ram_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              verify_en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_enable,
    output logic              mem_r_w,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr
);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] base_q, base_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [CNT_W-1:0]  len_q, len_nx;
    logic [CNT_W-1:0]  rem_q, rem_nx;
    logic              verify_q, verify_nx;
    mem_req_t          req_q, req_nx;
    logic              in_ready_nx, busy_nx, done_nx, error_nx;
    logic [ADDR_W-1:0] err_addr_nx;
    logic [CNT_W-1:0]  clamped;
    logic              shadow_we;
    logic [DATA_W-1:0] shadow [DEPTH];

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            base_q   <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            rem_q    <= '0;
            verify_q <= 1'b0;
            req_q    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_addr <= '0;
        end else begin
            state    <= state_nx;
            base_q   <= base_nx;
            addr_q   <= addr_nx;
            len_q    <= len_nx;
            rem_q    <= rem_nx;
            verify_q <= verify_nx;
            req_q    <= req_nx;
            in_ready <= in_ready_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            error    <= error_nx;
            err_addr <= err_addr_nx;
        end
    end

    // Shadow copy of every accepted word, used as the verify reference.
    always_ff @(posedge clk) begin
        if (shadow_we && !reset) begin
            shadow[addr_q] <= in_data;
        end
    end

    // Next state; addr_q is the write pointer in WRITE and the read pointer in verify.
    always_comb begin
        state_nx    = state;
        base_nx     = base_q;
        addr_nx     = addr_q;
        len_nx      = len_q;
        rem_nx      = rem_q;
        verify_nx   = verify_q;
        req_nx      = '0;
        error_nx    = error;
        err_addr_nx = err_addr;
        shadow_we   = 1'b0;
        clamped     = clamp_count(count);

        case (state)
            IDLE: begin
                if (start) begin
                    base_nx     = base_addr;
                    addr_nx     = base_addr;
                    len_nx      = clamped;
                    rem_nx      = clamped;
                    verify_nx   = verify_en;
                    error_nx    = 1'b0;
                    err_addr_nx = '0;
                    state_nx    = (clamped == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (in_valid && in_ready) begin
                    shadow_we = 1'b1;
                    req_nx    = '{en: 1'b1, r_w: 1'b1, addr: addr_q, din: in_data};
                    addr_nx   = addr_q + ADDR_W'(1);
                    rem_nx    = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        if (verify_q) begin
                            state_nx = VERIFY_RD;
                            addr_nx  = base_q;
                            rem_nx   = len_q;
                        end else begin
                            state_nx = DONE;
                        end
                    end
                end
            end
            VERIFY_RD: begin
                req_nx   = '{en: 1'b1, r_w: 1'b0, addr: addr_q, din: '0};
                state_nx = VERIFY_CMP;
            end
            VERIFY_CMP: begin
                // Only the first mismatch of a burst is recorded.
                if ((mem_dout != shadow[addr_q]) && !error) begin
                    error_nx    = 1'b1;
                    err_addr_nx = addr_q;
                end
                addr_nx  = addr_q + ADDR_W'(1);
                rem_nx   = rem_q - CNT_W'(1);
                state_nx = (rem_q == CNT_W'(1)) ? DONE : VERIFY_RD;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        in_ready_nx = (state_nx == WRITE);
        busy_nx     = (state_nx != IDLE);
        done_nx     = (state_nx == DONE);
    end

    assign mem_enable = req_q.en;
    assign mem_r_w    = req_q.r_w;
    assign mem_addr   = req_q.addr;
    assign mem_din    = req_q.din;

endmodule
